// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared RV32 load/store encodings, fault causes, pipeline stage type and byte-enable helper
package riscv_mem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISAL   = 2'b01;
  localparam logic [1:0] CAUSE_RANGE   = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b11;
  typedef struct packed {
    logic        valid;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [1:0]  cause;
    logic [31:0] word;
  } stage_t;
  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    return funct3[1:0] == 2'b00 ? 4'b0001 << lane :
           funct3[1:0] == 2'b01 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/half of a word and sign/zero-extends it by funct3
// ports: word (stored word), lane (byte address bits [1:0]), funct3 (load size), rdata (extended result)
module load_align
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    rdata = funct3 == F3_B  ? {{24{b[7]}}, b} :
            funct3 == F3_BU ? {24'b0, b} :
            funct3 == F3_H  ? {{16{h[15]}}, h} :
            funct3 == F3_HU ? {16'b0, h} : word;
  end
endmodule

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressable RV32 data memory with fault decode and configurable read latency
// ports: clk/rst (sync active-high); req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata request side;
//        resp_valid/resp_rdata/resp_fault/resp_cause in-order response side, READ_LATENCY cycles after accept
module data_memory_lsu
  import riscv_mem_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output logic                  resp_fault,
  output logic [1:0]            resp_cause
);
  localparam int AW = $clog2(DEPTH_WORDS);
  if (XLEN != 32) begin : g_xlen_chk
    $error("data_memory_lsu: XLEN must be 32");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_lat_chk
    $error("data_memory_lsu: READ_LATENCY must be 1..4");
  end
  if ((1 << AW) != DEPTH_WORDS || ADDR_WIDTH <= AW + 2) begin : g_depth_chk
    $error("data_memory_lsu: DEPTH_WORDS must be a power of two addressable by ADDR_WIDTH");
  end
  logic [31:0]   mem [DEPTH_WORDS];
  stage_t        pipe [READ_LATENCY];
  logic          acc, legal, misal, oor;
  logic [1:0]    cause;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wrep, aligned;
  always_comb begin
    acc   = req_valid && req_ready && !rst;
    idx   = req_addr[AW+1:2];
    legal = req_funct3 inside {F3_B, F3_H, F3_W} || (!req_we && req_funct3 inside {F3_BU, F3_HU});
    misal = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    oor   = |req_addr[ADDR_WIDTH-1:AW+2];
    cause = !legal ? CAUSE_ILLEGAL : misal ? CAUSE_MISAL : oor ? CAUSE_RANGE : CAUSE_NONE;
    be    = byte_en(req_funct3, req_addr[1:0]);
    wrep  = req_funct3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
            req_funct3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
  end
  always_ff @(posedge clk)
    if (acc && req_we && cause == CAUSE_NONE)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
  load_align u_align (
    .word   (pipe[READ_LATENCY-1].word),
    .lane   (pipe[READ_LATENCY-1].lane),
    .funct3 (pipe[READ_LATENCY-1].funct3),
    .rdata  (aligned)
  );
  // stores and faulting loads carry a zero word, so the aligned result is already 0 for them
  always_ff @(posedge clk)
    if (rst) begin
      req_ready  <= 1'b0;
      for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
      resp_cause <= CAUSE_NONE;
    end else begin
      req_ready  <= 1'b1;
      pipe[0]    <= '{valid: acc, funct3: req_funct3, lane: req_addr[1:0],
                      cause: acc ? cause : CAUSE_NONE,
                      word: acc && !req_we && cause == CAUSE_NONE ? mem[idx] : '0};
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
      resp_valid <= pipe[READ_LATENCY-1].valid;
      resp_rdata <= aligned;
      resp_fault <= pipe[READ_LATENCY-1].cause != CAUSE_NONE;
      resp_cause <= pipe[READ_LATENCY-1].cause;
    end
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: directed table-driven checks of data_memory_lsu with an in-order response scoreboard
module tb_data_memory_lsu;
  import riscv_mem_pkg::*;
  localparam int LAT = 3;
  logic        clk = 0, rst = 1, req_valid = 0, req_we = 0;
  logic [2:0]  req_funct3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_fault;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_cause;
  always #5 clk = ~clk;
  data_memory_lsu #(.XLEN(32), .ADDR_WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault), .resp_cause(resp_cause)
  );
  typedef struct {logic [31:0] rdata; logic [1:0] cause; int due;} exp_t;
  typedef struct {logic we; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic [1:0] cause;} vec_t;
  exp_t q[$];
  exp_t e;
  vec_t vt[$];
  int cyc = 0, n_vec = 0, n_bad = 0, pulses = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (resp_valid) begin
      pulses++;
      if (q.size() == 0) chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
      else begin
        e = q.pop_front();
        chk("resp_cycle", 32'(cyc), 32'(e.due));
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.cause != 2'b00});
        chk("resp_cause", {30'b0, resp_cause}, {30'b0, e.cause});
      end
    end else if (q.size() != 0 && q[0].due <= cyc) begin
      chk("missing_resp", {31'b0, resp_valid}, 32'd1);
      void'(q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata, logic [31:0] rdata, logic [1:0] cause);
    req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    q.push_back(exp_t'{rdata, cause, cyc + 1 + LAT});
    tick();
  endtask
  task automatic drain();
    int k;
    k = 0;
    req_valid = 0;
    while (q.size() != 0 && k < 20) begin tick(); k++; end
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
    tick();
  endtask
  initial begin
    vt.push_back(vec_t'{1'b1, F3_W,   32'h10,       32'hDEADBEEF, 32'h0,        2'd0});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h10,       32'h0,        32'hDEADBEEF, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_B,   32'h13,       32'h0,        32'hFFFFFFDE, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_BU,  32'h13,       32'h0,        32'h000000DE, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_H,   32'h12,       32'h0,        32'hFFFFDEAD, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_HU,  32'h12,       32'h0,        32'h0000DEAD, 2'd0});
    vt.push_back(vec_t'{1'b1, F3_B,   32'h11,       32'hFFFFFF55, 32'h0,        2'd0});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h10,       32'h0,        32'hDEAD55EF, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_H,   32'h21,       32'h0,        32'h0,        2'd1});
    vt.push_back(vec_t'{1'b1, F3_W,   32'h20,       32'h01020304, 32'h0,        2'd0});
    vt.push_back(vec_t'{1'b1, F3_W,   32'h22,       32'hFFFFFFFF, 32'h0,        2'd1});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h20,       32'h0,        32'h01020304, 2'd0});
    vt.push_back(vec_t'{1'b0, 3'b011, 32'h20,       32'h0,        32'h0,        2'd3});
    vt.push_back(vec_t'{1'b1, F3_BU,  32'h20,       32'hFF,       32'h0,        2'd3});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h20,       32'h0,        32'h01020304, 2'd0});
    vt.push_back(vec_t'{1'b1, F3_W,   32'h0,        32'h77777777, 32'h0,        2'd0});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h1000,     32'h0,        32'h0,        2'd2});
    vt.push_back(vec_t'{1'b1, F3_W,   32'h1000,     32'h12345678, 32'h0,        2'd2});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h0,        32'h0,        32'h77777777, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_H,   32'h1001,     32'h0,        32'h0,        2'd1});
    vt.push_back(vec_t'{1'b0, 3'b111, 32'h1001,     32'h0,        32'h0,        2'd3});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h80000010, 32'h0,        32'h0,        2'd2});
    vt.push_back(vec_t'{1'b1, F3_W,   32'h30,       32'h0,        32'h0,        2'd0});
    vt.push_back(vec_t'{1'b1, F3_H,   32'h32,       32'h1234BEEF, 32'h0,        2'd0});
    vt.push_back(vec_t'{1'b0, F3_W,   32'h30,       32'h0,        32'hBEEF0000, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_HU,  32'h32,       32'h0,        32'h0000BEEF, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_B,   32'h32,       32'h0,        32'hFFFFFFEF, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_BU,  32'h31,       32'h0,        32'h0,        2'd0});
    vt.push_back(vec_t'{1'b1, F3_W,   32'hFFC,      32'hA5A5A5A5, 32'h0,        2'd0});
    vt.push_back(vec_t'{1'b0, F3_W,   32'hFFC,      32'h0,        32'hA5A5A5A5, 2'd0});
    vt.push_back(vec_t'{1'b0, F3_HU,  32'hFFE,      32'h0,        32'h0000A5A5, 2'd0});
    repeat (2) tick();
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("rst_resp_cause", {30'b0, resp_cause}, 32'd0);
    rst = 0;
    tick();
    chk("ready_after_rst", {31'b0, req_ready}, 32'd1);
    issue(1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 2'd0);
    drain();
    rst = 1; req_valid = 1; req_we = 1; req_funct3 = F3_W; req_addr = 32'h40; req_wdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_hold_valid", {31'b0, resp_valid}, 32'd0);
    end
    rst = 0; req_valid = 0;
    tick();
    chk("ready_after_rst2", {31'b0, req_ready}, 32'd1);
    issue(1'b0, F3_W, 32'h40, 32'h0, 32'hCAFEF00D, 2'd0);
    drain();
    foreach (vt[i]) issue(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].cause);
    drain();
    pulses = 0;
    issue(1'b0, F3_W,  32'h10,  32'h0, 32'hDEAD55EF, 2'd0);
    issue(1'b0, F3_W,  32'h20,  32'h0, 32'h01020304, 2'd0);
    issue(1'b0, F3_BU, 32'h21,  32'h0, 32'h00000003, 2'd0);
    issue(1'b0, F3_B,  32'h33,  32'h0, 32'hFFFFFFBE, 2'd0);
    issue(1'b0, F3_HU, 32'h30,  32'h0, 32'h00000000, 2'd0);
    issue(1'b0, F3_W,  32'hFFC, 32'h0, 32'hA5A5A5A5, 2'd0);
    issue(1'b0, F3_H,  32'h42,  32'h0, 32'hFFFFCAFE, 2'd0);
    issue(1'b0, F3_BU, 32'h40,  32'h0, 32'h0000000D, 2'd0);
    drain();
    chk("burst_pulses", 32'(pulses), 32'd8);
    pulses = 0;
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 2'd0);
    issue(1'b0, F3_W, 32'h20, 32'h0, 32'h01020304, 2'd0);
    issue(1'b0, F3_W, 32'h30, 32'h0, 32'hBEEF0000, 2'd0);
    rst = 1; req_valid = 1; req_we = 1; req_funct3 = F3_W; req_addr = 32'h10; req_wdata = 32'h0BADF00D;
    while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
    repeat (2) tick();
    rst = 0; req_valid = 0;
    repeat (LAT + 3) tick();
    chk("rst_drop_pulses", 32'(pulses), 32'd0);
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEAD55EF, 2'd0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
